// File: rtl/isqrt_shared_arbiter.sv
// isqrt_shared_arbiter: shares one pipelined, in-order isqrt unit among
// N_CLIENTS requesters. A round-robin arbiter grants one request per cycle.
// The arbiter pushes the client ID of each grant into a tag FIFO. Each
// returning result goes to the client at the FIFO head.
// Optional build macro ISQRT_ARB_PERF_CNT_EN adds two counters, grant_cnt and
// stall_cnt.
module isqrt_shared_arbiter #(
  parameter int N_CLIENTS = 3,
  parameter int TAG_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CLIENTS-1:0]    cl_x_vld,
  input  logic [32*N_CLIENTS-1:0] cl_x,
  output logic [N_CLIENTS-1:0]    cl_x_rdy,
  output logic [N_CLIENTS-1:0]    cl_y_vld,
  output logic [15:0]             cl_y,
  output logic                    isqrt_x_vld,
  output logic [31:0]             isqrt_x,
  input  logic                    isqrt_y_vld,
  input  logic [15:0]             isqrt_y,
  output logic                    tag_err
`ifdef ISQRT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]             grant_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int ID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int AW   = $clog2(TAG_DEPTH);
  localparam int CW   = AW + 1;

  // Tag FIFO storage and state. The pointers wrap naturally because
  // TAG_DEPTH is a power of two.
  logic [ID_W-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            tag_err_q, tag_err_d;

  logic            full, empty;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic            push, pop;
  logic [ID_W-1:0] head;
  logic [31:0]     cl_x_arr [N_CLIENTS];

  // Split the packed operand bus into one 32-bit word per client.
  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_operand
    assign cl_x_arr[gi] = cl_x[32*gi +: 32];
  end

  assign full  = (count_q == CW'(TAG_DEPTH));
  assign empty = (count_q == '0);
  assign push  = grant_vld;
  assign pop   = isqrt_y_vld && !empty;
  assign head  = tag_mem[rd_ptr_q];

  // Round-robin scan starting at rr_ptr_q. A full FIFO blocks every grant,
  // even when a pop happens in the same cycle.
  always_comb begin
    logic [ID_W:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_CLIENTS)) begin
        idx = idx - (ID_W+1)'(N_CLIENTS);
      end
      if (!grant_vld && !full && cl_x_vld[idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
  end

  // Drive the request and result outputs. Both paths are combinational, so
  // they add no latency.
  always_comb begin
    cl_x_rdy    = '0;
    cl_y_vld    = '0;
    isqrt_x_vld = grant_vld;
    isqrt_x     = '0;
    cl_y        = isqrt_y;
    if (grant_vld) begin
      cl_x_rdy[grant_id] = 1'b1;
      isqrt_x            = cl_x_arr[grant_id];
    end
    if (pop) begin
      cl_y_vld[head] = 1'b1;
    end
  end

  // Compute next state for the FIFO pointers, the arbiter pointer and the
  // sticky error flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rr_ptr_d  = rr_ptr_q;
    tag_err_d = tag_err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (grant_id == ID_W'(N_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (isqrt_y_vld && empty) begin
      tag_err_d = 1'b1;
    end
  end

  // Update the state registers. Reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
      tag_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      tag_err_q <= tag_err_d;
    end
  end

  // Write the granted client ID into the tag FIFO. The storage has no reset,
  // because the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      tag_mem[wr_ptr_q] <= grant_id;
    end
  end

  assign tag_err = tag_err_q;

`ifdef ISQRT_ARB_PERF_CNT_EN
  logic        stall;
  logic [31:0] grant_cnt_q, stall_cnt_q;

  assign stall = (|cl_x_vld) && !grant_vld;

  // Count grants and the cycles where a pending request is blocked by a full
  // FIFO. Both counters wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push)  grant_cnt_q <= grant_cnt_q + 32'd1;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
